// File: rtl/seven_seg_bus_writer.sv
// Bus-master sequencer: writes the four nibbles of a 16-bit display value as
// byte writes to consecutive peripheral addresses, with an optional idle gap between writes.
`timescale 1ns/1ps
module seven_seg_bus_writer #(
    parameter logic [7:0]  BASE_ADDR  = 8'hD0,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_value,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_bus_req,
    input  logic        i_bus_gnt,
    output logic [7:0]  o_bus_addr,
    output logic [7:0]  o_bus_data,
    output logic        o_bus_we
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_idx;
    logic [1:0]  w_next_idx;
    logic [7:0]  r_gap;
    logic [7:0]  w_next_gap;
    logic [15:0] r_value;
    logic [3:0]  w_nibble;

    // NOTE: state uses non-blocking assignments and an asynchronous reset so every
    // output, being decoded from registers only, drops the instant reset rises.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_gap   <= 8'd0;
            r_value <= 16'h0000;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_gap   <= w_next_gap;
            if (r_state == S_IDLE && i_start) begin
                r_value <= i_value;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_next_gap   = r_gap;
        unique case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_REQ;
                    w_next_idx   = 2'd0;
                end
            end
            S_REQ: begin
                if (i_bus_gnt) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_idx == 2'd3) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_idx = r_idx + 2'd1;
                    if (GAP_CYCLES == 0) begin
                        w_next_state = i_bus_gnt ? S_WRITE : S_REQ;
                    end else begin
                        w_next_state = S_GAP;
                        w_next_gap   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                // Losing the grant mid-gap re-arbitrates; idx already points at the next digit.
                if (!i_bus_gnt) begin
                    w_next_state = S_REQ;
                end else if (r_gap == 8'd0) begin
                    w_next_state = S_WRITE;
                end else begin
                    w_next_gap = r_gap - 8'd1;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_nibble   = r_value[{r_idx, 2'b00} +: 4];
    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_bus_req  = (r_state == S_REQ) || (r_state == S_WRITE) || (r_state == S_GAP);
    assign o_bus_we   = (r_state == S_WRITE);
    assign o_bus_addr = o_bus_we ? (BASE_ADDR + {6'd0, r_idx}) : 8'h00;
    assign o_bus_data = o_bus_we ? {4'h0, w_nibble} : 8'h00;

endmodule

// File: tb/tb_seven_seg_bus_writer.sv
// Bench for seven_seg_bus_writer: two instances (gap 2 at D0, gap 0 at FE), traces captured
// per cycle and compared against write times/addresses derived arithmetically from the timing rules.
`timescale 1ns/1ps
module tb_seven_seg_bus_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_s [2];
    logic [15:0] value_s [2];
    logic        gnt_s   [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic        req_s   [2];
    logic        we_s    [2];
    logic [7:0]  addr_s  [2];
    logic [7:0]  data_s  [2];

    int errors = 0;
    int checks = 0;

    int         wr_rel  [$];
    logic [7:0] wr_addr [$];
    logic [7:0] wr_data [$];
    int         done_rel[$];
    int         busy_first, busy_last, busy_n, bus_bad;

    int         exp_rel [$];
    logic [7:0] exp_addr[$];
    logic [7:0] exp_data[$];
    int         exp_done;

    always #5 clk = ~clk;

    seven_seg_bus_writer u_dut0 (
        .i_clk(clk), .i_reset(rst), .i_start(start_s[0]), .i_value(value_s[0]),
        .o_busy(busy_s[0]), .o_done(done_s[0]), .o_bus_req(req_s[0]), .i_bus_gnt(gnt_s[0]),
        .o_bus_addr(addr_s[0]), .o_bus_data(data_s[0]), .o_bus_we(we_s[0])
    );

    seven_seg_bus_writer #(.BASE_ADDR(8'hFE), .GAP_CYCLES(0)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start_s[1]), .i_value(value_s[1]),
        .o_busy(busy_s[1]), .o_done(done_s[1]), .o_bus_req(req_s[1]), .i_bus_gnt(gnt_s[1]),
        .o_bus_addr(addr_s[1]), .o_bus_data(data_s[1]), .o_bus_we(we_s[1])
    );

    function automatic int gap_of(input int sel);
        return (sel == 0) ? 2 : 0;
    endfunction

    function automatic int base_of(input int sel);
        return (sel == 0) ? 'hD0 : 'hFE;
    endfunction

    function automatic logic [19:0] outs_of(input int sel);
        return {busy_s[sel], done_s[sel], req_s[sel], we_s[sel], addr_s[sel], data_s[sel]};
    endfunction

    // Reference: with the grant held low for d cycles after REQ and high afterwards, digit k
    // is written at t+2+d+k*(1+G) to base+k, carrying nibble k; DONE follows at t+6+3G+d.
    task automatic model_run(input int sel, input logic [15:0] val, input int d);
        int g;
        g = gap_of(sel);
        exp_rel.delete(); exp_addr.delete(); exp_data.delete();
        for (int k = 0; k < 4; k++) begin
            exp_rel.push_back(2 + d + k * (1 + g));
            exp_addr.push_back(8'((base_of(sel) + k) % 256));
            exp_data.push_back({4'h0, 4'((val >> (4 * k)) & 16'hF)});
        end
        exp_done = 6 + 3 * g + d;
    endtask

    // Called at posedge+1; START is driven in relative cycle 0 (edge t = end of cycle 0).
    task automatic run_seq(input int sel, input logic [15:0] val, input int gnt_lo, input int gnt_hi,
                           input int start2_at, input logic [15:0] val2, input int rst_at,
                           input int ncyc);
        logic prev_we;
        wr_rel.delete(); wr_addr.delete(); wr_data.delete(); done_rel.delete();
        busy_first = -1; busy_last = -1; busy_n = 0; bus_bad = 0; prev_we = 1'b0;
        for (int rel = 0; rel < ncyc; rel++) begin
            start_s[sel] = (rel == 0) || (rel == start2_at);
            value_s[sel] = (rel == 0) ? val : ((rel == start2_at) ? val2 : ~val);
            gnt_s[sel]   = !(rel >= gnt_lo && rel < gnt_hi);
            if (rel == rst_at) begin
                #1 rst = 1'b1;
                #1 checks++;
                if (outs_of(sel) !== 20'h0) begin
                    errors++;
                    $display("FAIL reset_immediate: outputs got %h required 00000", outs_of(sel));
                end
            end
            @(negedge clk);
            if (busy_s[sel]) begin
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
                busy_n++;
            end
            if (we_s[sel]) begin
                wr_rel.push_back(rel);
                wr_addr.push_back(addr_s[sel]);
                wr_data.push_back(data_s[sel]);
                if (!req_s[sel]) bus_bad++;
                if (prev_we && gap_of(sel) != 0) bus_bad++;
            end else if (addr_s[sel] !== 8'h00 || data_s[sel] !== 8'h00) begin
                bus_bad++;
            end
            prev_we = we_s[sel];
            if (done_s[sel]) done_rel.push_back(rel);
            if (rel == rst_at) rst = 1'b0;
            @(posedge clk);
            #1;
        end
        start_s[sel] = 1'b0;
        gnt_s[sel]   = 1'b1;
    endtask

    task automatic compare_trace(input string tag);
        int got_done;
        checks++;
        if (wr_rel.size() != exp_rel.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", tag, wr_rel.size(), exp_rel.size());
        end
        for (int k = 0; k < exp_rel.size() && k < wr_rel.size(); k++) begin
            checks++;
            if (wr_rel[k] != exp_rel[k] || wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
                errors++;
                $display("FAIL %s write%0d: got t+%0d %h/%h required t+%0d %h/%h", tag, k,
                         wr_rel[k], wr_addr[k], wr_data[k], exp_rel[k], exp_addr[k], exp_data[k]);
            end
        end
        got_done = (done_rel.size() == 1) ? done_rel[0] : -1;
        checks++;
        if (got_done != exp_done) begin
            errors++;
            $display("FAIL %s done: got t+%0d (pulses %0d) required t+%0d", tag, got_done,
                     done_rel.size(), exp_done);
        end
        checks++;
        if (busy_first != 1 || busy_last != exp_done || busy_n != exp_done) begin
            errors++;
            $display("FAIL %s busy: got t+%0d..t+%0d (%0d cycles) required t+1..t+%0d", tag,
                     busy_first, busy_last, busy_n, exp_done);
        end
        checks++;
        if (bus_bad != 0) begin
            errors++;
            $display("FAIL %s bus_idle: got %0d bad cycles required 0", tag, bus_bad);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (outs_of(s) !== 20'h0) begin
                errors++;
                $display("FAIL reset_state%0d: outputs got %h required 00000", s, outs_of(s));
            end
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        run_seq(0, 16'h1234, 0, 0, -1, 16'h0, -1, 16);
        model_run(0, 16'h1234, 0);
        compare_trace("basic");
    endtask

    task automatic test_grant_delay();
        run_seq(0, 16'h1234, 1, 6, -1, 16'h0, -1, 20);
        model_run(0, 16'h1234, 5);
        compare_trace("grant_delay");
    endtask

    task automatic test_preempt();
        int last;
        // Grant lost during the gap after digit 1: re-arbitrate, resume at digit 2.
        run_seq(0, 16'h1234, 6, 9, -1, 16'h0, -1, 24);
        model_run(0, 16'h1234, 0);
        checks++;
        if (wr_rel.size() != 4) begin
            errors++;
            $display("FAIL preempt_count: got %0d writes required 4", wr_rel.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (wr_addr[k] !== exp_addr[k] || wr_data[k] !== exp_data[k]) begin
                    errors++;
                    $display("FAIL preempt_write%0d: got %h/%h required %h/%h", k,
                             wr_addr[k], wr_data[k], exp_addr[k], exp_data[k]);
                end
            end
            checks++;
            if (wr_rel[0] != 2 || wr_rel[1] != 5 || wr_rel[2] < 10 || wr_rel[3] != wr_rel[2] + 3) begin
                errors++;
                $display("FAIL preempt_timing: got t+%0d,%0d,%0d,%0d required 2,5,>=10,+3",
                         wr_rel[0], wr_rel[1], wr_rel[2], wr_rel[3]);
            end
            last = wr_rel[3];
            checks++;
            if (done_rel.size() != 1 || busy_last != last + 1 || done_rel[0] != last + 1) begin
                errors++;
                $display("FAIL preempt_done: got %0d pulses, busy_last t+%0d required one at t+%0d",
                         done_rel.size(), busy_last, last + 1);
            end
        end
        // Zero-gap instance: grant lost at the WRITE->WRITE hand-off for two cycles.
        run_seq(1, 16'hA5C3, 3, 5, -1, 16'h0, -1, 14);
        model_run(1, 16'hA5C3, 0);
        exp_rel[2] = 6;
        exp_rel[3] = 7;
        exp_done   = 8;
        compare_trace("preempt_handoff");
    endtask

    task automatic test_ignore_start();
        run_seq(0, 16'h1234, 0, 0, 4, 16'hFFFF, -1, 13);
        model_run(0, 16'h1234, 0);
        compare_trace("ignore_busy_start");
    endtask

    task automatic test_back_to_back();
        // START during DONE is ignored; START one cycle later starts a fresh sequence.
        run_seq(0, 16'h5A69, 0, 0, 12, 16'hFFFF, -1, 13);
        model_run(0, 16'h5A69, 0);
        compare_trace("start_in_done");
        run_seq(0, 16'h0F1E, 0, 0, -1, 16'h0, -1, 15);
        model_run(0, 16'h0F1E, 0);
        compare_trace("start_after_done");
    endtask

    task automatic test_reset_mid();
        run_seq(0, 16'h1234, 0, 0, -1, 16'h0, 6, 16);
        checks++;
        if (wr_rel.size() != 2 || done_rel.size() != 0 || busy_last != 5) begin
            errors++;
            $display("FAIL reset_mid: got %0d writes %0d dones busy_last t+%0d required 2 0 t+5",
                     wr_rel.size(), done_rel.size(), busy_last);
        end
        run_seq(0, 16'h9876, 0, 0, -1, 16'h0, -1, 15);
        model_run(0, 16'h9876, 0);
        compare_trace("after_reset");
    endtask

    task automatic test_gap0();
        run_seq(1, 16'hA5C3, 0, 0, -1, 16'h0, -1, 10);
        model_run(1, 16'hA5C3, 0);
        compare_trace("gap0_wrap");
    endtask

    task automatic test_random();
        int sel, d, done_at, s2;
        logic [15:0] val;
        for (int it = 0; it < 10; it++) begin
            sel     = int'($urandom_range(0, 1));
            val     = 16'($urandom);
            d       = int'($urandom_range(0, 6));
            done_at = 6 + 3 * gap_of(sel) + d;
            s2      = int'($urandom_range(1, done_at));
            run_seq(sel, val, 1, 1 + d, s2, 16'($urandom), -1, done_at + 2);
            model_run(sel, val, d);
            compare_trace($sformatf("random%0d", it));
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            start_s[s] = 1'b0;
            value_s[s] = 16'h0000;
            gnt_s[s]   = 1'b1;
        end
        test_reset();
        test_basic();
        test_grant_delay();
        test_preempt();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_gap0();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
